// File: rtl/fft_peak_detect.sv
// rtl/fft_peak_detect.sv - per-channel |X|^2 peak search over FFT frames with AXI-Stream result output
module fft_peak_detect #(
    parameter int FFT_LEN            = 8192,
    parameter int FFT_CHANNELS       = 2,
    parameter int FFT_AXI_DATA_WIDTH = 32,
    parameter int FFT_INDEX_LEN      = 32,
    parameter int SKIP_BINS          = 1
) (
    input  logic                                       aclk,
    input  logic                                       aresetn,
    input  logic [FFT_CHANNELS*FFT_AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                                       s_axis_tvalid,
    input  logic                                       s_axis_tlast,
    output logic                                       s_axis_tready,
    input  logic [FFT_INDEX_LEN-1:0]                   s_index,
    output logic [63:0]                                m_axis_tdata,
    output logic [7:0]                                 m_axis_tuser,
    output logic                                       m_axis_tvalid,
    output logic                                       m_axis_tlast,
    input  logic                                       m_axis_tready,
    output logic                                       frame_err
);

    // Each channel word is {im, re}; the squared magnitude fits the full word width unsigned.
    localparam int DW    = FFT_AXI_DATA_WIDTH;
    localparam int HW    = FFT_AXI_DATA_WIDTH / 2;
    localparam int MAG_W = 2 * HW;
    localparam int IDX_W = FFT_INDEX_LEN;
    localparam int CH_W  = (FFT_CHANNELS > 1) ? $clog2(FFT_CHANNELS) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(FFT_CHANNELS - 1);

    localparam logic [1:0] ST_CLEAR  = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic        drain_q;
    logic [31:0] cnt_q;
    logic        accept;

    // Stage 1: captured input beat
    logic                   s1_valid_q;
    logic                   s1_last_q;
    logic                   s1_err_q;
    logic [IDX_W-1:0]       s1_idx_q;
    logic signed [HW-1:0]   s1_re_q [FFT_CHANNELS];
    logic signed [HW-1:0]   s1_im_q [FFT_CHANNELS];

    // Stage 2: registered magnitudes
    logic                   s2_valid_q;
    logic [IDX_W-1:0]       s2_idx_q;
    logic [MAG_W-1:0]       s2_mag_q [FFT_CHANNELS];
    logic                   frame_err_q;

    // Running peaks
    logic [MAG_W-1:0]       peak_mag_q [FFT_CHANNELS];
    logic [IDX_W-1:0]       peak_idx_q [FFT_CHANNELS];
    logic [31:0]            peak_idx32 [FFT_CHANNELS];
    logic [63:0]            rec_data   [FFT_CHANNELS];

    logic signed [HW-1:0]   in_re  [FFT_CHANNELS];
    logic signed [HW-1:0]   in_im  [FFT_CHANNELS];
    logic signed [MAG_W-1:0] re_sq [FFT_CHANNELS];
    logic signed [MAG_W-1:0] im_sq [FFT_CHANNELS];
    logic [MAG_W-1:0]       mag_d  [FFT_CHANNELS];

    logic [CH_W-1:0]        ch_q;
    logic [CH_W-1:0]        ch_nxt;
    logic                   m_tvalid_q;
    logic                   m_tlast_q;
    logic [63:0]            m_tdata_q;
    logic [7:0]             m_tuser_q;
    logic                   bin_ok;
    logic [32:0]            cnt_plus;

    // The upstream is only held off outside ACCUM; within ACCUM every valid beat is taken.
    assign s_axis_tready = (state_q == ST_ACCUM);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign cnt_plus      = {1'b0, cnt_q} + 33'd1;
    assign ch_nxt        = ch_q + 1'b1;

    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tuser  = m_tuser_q;
    assign frame_err     = frame_err_q;

    // DC rejection: with SKIP_BINS of 0 every bin takes part in the search.
    if (SKIP_BINS == 0) begin : g_no_skip
        assign bin_ok = 1'b1;
    end else begin : g_skip
        assign bin_ok = (s2_idx_q >= IDX_W'(SKIP_BINS));
    end

    // Result index field is always 32 bits wide.
    if (IDX_W >= 32) begin : g_idx_trunc
        // Truncate the bin index into the record.
        always_comb begin
            for (int c = 0; c < FFT_CHANNELS; c++) begin
                peak_idx32[c] = peak_idx_q[c][31:0];
            end
        end
    end else begin : g_idx_ext
        // Zero-extend the bin index into the record.
        always_comb begin
            for (int c = 0; c < FFT_CHANNELS; c++) begin
                peak_idx32[c] = {{(32 - IDX_W){1'b0}}, peak_idx_q[c]};
            end
        end
    end

    // Split channel words and form the result records.
    always_comb begin
        for (int c = 0; c < FFT_CHANNELS; c++) begin
            in_re[c]    = s_axis_tdata[c*DW +: HW];
            in_im[c]    = s_axis_tdata[c*DW+HW +: HW];
            rec_data[c] = {peak_idx32[c], peak_mag_q[c]};
        end
    end

    // |X|^2 from stage 1; each square is non-negative, so the sum cannot wrap unsigned.
    always_comb begin
        for (int c = 0; c < FFT_CHANNELS; c++) begin
            re_sq[c] = MAG_W'(s1_re_q[c]) * MAG_W'(s1_re_q[c]);
            im_sq[c] = MAG_W'(s1_im_q[c]) * MAG_W'(s1_im_q[c]);
            mag_d[c] = $unsigned(re_sq[c]) + $unsigned(im_sq[c]);
        end
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR:  state_d = ST_ACCUM;
            ST_ACCUM:  if (accept && s_axis_tlast) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_q) state_d = ST_REPORT;
            ST_REPORT: if (m_tvalid_q && m_axis_tready && (ch_q == LAST_CH)) state_d = ST_CLEAR;
            default:   state_d = ST_CLEAR;
        endcase
    end

    // State register and the two-cycle drain timer.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_CLEAR;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == ST_DRAIN) && !drain_q;
        end
    end

    // Saturating beat counter, restarted for every frame.
    always_ff @(posedge aclk) begin
        if (!aresetn || (state_q == ST_CLEAR)) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // Stage 1: register the accepted beat and whether its length check already fails.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_idx_q   <= '0;
            for (int c = 0; c < FFT_CHANNELS; c++) begin
                s1_re_q[c] <= '0;
                s1_im_q[c] <= '0;
            end
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_last_q <= s_axis_tlast;
                s1_err_q  <= (cnt_plus != 33'(FFT_LEN));
                s1_idx_q  <= s_index;
                for (int c = 0; c < FFT_CHANNELS; c++) begin
                    s1_re_q[c] <= in_re[c];
                    s1_im_q[c] <= in_im[c];
                end
            end
        end
    end

    // Stage 2: register magnitudes; the length error surfaces one edge after the tlast beat.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s2_valid_q  <= 1'b0;
            s2_idx_q    <= '0;
            frame_err_q <= 1'b0;
            for (int c = 0; c < FFT_CHANNELS; c++) begin
                s2_mag_q[c] <= '0;
            end
        end else begin
            s2_valid_q  <= s1_valid_q;
            s2_idx_q    <= s1_idx_q;
            frame_err_q <= s1_valid_q & s1_last_q & s1_err_q;
            for (int c = 0; c < FFT_CHANNELS; c++) begin
                s2_mag_q[c] <= mag_d[c];
            end
        end
    end

    // Peak tracking: strictly greater wins, so on ties the earliest bin is kept.
    always_ff @(posedge aclk) begin
        if (!aresetn || (state_q == ST_CLEAR)) begin
            for (int c = 0; c < FFT_CHANNELS; c++) begin
                peak_mag_q[c] <= '0;
                peak_idx_q[c] <= '0;
            end
        end else if (s2_valid_q && bin_ok) begin
            for (int c = 0; c < FFT_CHANNELS; c++) begin
                if (s2_mag_q[c] > peak_mag_q[c]) begin
                    peak_mag_q[c] <= s2_mag_q[c];
                    peak_idx_q[c] <= s2_idx_q;
                end
            end
        end
    end

    // Result emitter: one beat per channel, held until accepted.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tdata_q  <= '0;
            m_tuser_q  <= '0;
            ch_q       <= '0;
        end else if (state_q == ST_REPORT) begin
            if (!m_tvalid_q) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= rec_data[ch_q];
                m_tuser_q  <= 8'(ch_q);
                m_tlast_q  <= (ch_q == LAST_CH);
            end else if (m_axis_tready) begin
                if (ch_q == LAST_CH) begin
                    m_tvalid_q <= 1'b0;
                    m_tlast_q  <= 1'b0;
                    ch_q       <= '0;
                end else begin
                    ch_q      <= ch_nxt;
                    m_tdata_q <= rec_data[ch_nxt];
                    m_tuser_q <= 8'(ch_nxt);
                    m_tlast_q <= (ch_nxt == LAST_CH);
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// tb/tb_fft_peak_detect.sv - randomized model-checked bench for fft_peak_detect
module tb_fft_peak_detect;

    localparam int LEN = 16;
    localparam int CH  = 2;

    typedef struct packed {
        logic        last;
        logic [7:0]  user;
        logic [63:0] data;
    } beat_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic [31:0] s_index;
    logic        s_tready_a, s_tready_b;
    logic [63:0] m_tdata_a, m_tdata_b;
    logic [7:0]  m_tuser_a, m_tuser_b;
    logic        m_tvalid_a, m_tvalid_b;
    logic        m_tlast_a, m_tlast_b;
    logic        m_tready;
    logic        ferr_a, ferr_b;

    always #5 aclk = ~aclk;

    fft_peak_detect #(.FFT_LEN(LEN), .FFT_CHANNELS(CH), .FFT_AXI_DATA_WIDTH(32),
                      .FFT_INDEX_LEN(32), .SKIP_BINS(1)) dut_a (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready_a), .s_index(s_index),
        .m_axis_tdata(m_tdata_a), .m_axis_tuser(m_tuser_a), .m_axis_tvalid(m_tvalid_a),
        .m_axis_tlast(m_tlast_a), .m_axis_tready(m_tready), .frame_err(ferr_a));

    fft_peak_detect #(.FFT_LEN(LEN), .FFT_CHANNELS(CH), .FFT_AXI_DATA_WIDTH(32),
                      .FFT_INDEX_LEN(32), .SKIP_BINS(0)) dut_b (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready_b), .s_index(s_index),
        .m_axis_tdata(m_tdata_b), .m_axis_tuser(m_tuser_b), .m_axis_tvalid(m_tvalid_b),
        .m_axis_tlast(m_tlast_b), .m_axis_tready(m_tready), .frame_err(ferr_b));

    int    ntests = 0;
    int    nfail  = 0;
    int    cyc    = 0;
    int    last_e = -100;
    int    exp_err_cyc = -100;
    int    err_pulses  = 0;
    int    bp_left     = 0;
    bit    rst_done = 0, rdy_random = 0, bp_req = 0, rst_req = 0, rst_pending = 0, prev_valid = 0;
    int    fr_re [CH][32];
    int    fr_im [CH][32];
    beat_t exp_a[$], exp_b[$], got_a[$], got_b[$];

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: per channel, the first bin (index >= skip) with the largest |X|^2.
    task automatic model_frame(input int len);
        longint best, m;
        int     bi;
        beat_t  e;
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < CH; c++) begin
                best = 0;
                bi   = 0;
                for (int b = 0; b < len; b++) begin
                    m = longint'(fr_re[c][b]) * fr_re[c][b] + longint'(fr_im[c][b]) * fr_im[c][b];
                    if (b >= ((s == 0) ? 1 : 0) && m > best) begin
                        best = m;
                        bi   = b;
                    end
                end
                e.data = {32'(bi), 32'(best)};
                e.user = 8'(c);
                e.last = (c == CH - 1);
                if (s == 0) exp_a.push_back(e);
                else        exp_b.push_back(e);
            end
        end
    endtask

    function automatic int rand_val();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return int'($urandom_range(0, 6)) - 3;
            2:       return int'($urandom_range(0, 65535)) - 32768;
            default: return ($urandom_range(0, 1) != 0) ? 32767 : -32768;
        endcase
    endfunction

    task automatic clear_frame();
        for (int c = 0; c < CH; c++)
            for (int b = 0; b < 32; b++) begin
                fr_re[c][b] = 0;
                fr_im[c][b] = 0;
            end
    endtask

    task automatic rand_frame();
        for (int c = 0; c < CH; c++)
            for (int b = 0; b < 32; b++) begin
                fr_re[c][b] = rand_val();
                fr_im[c][b] = rand_val();
            end
    endtask

    task automatic send_frame(input int len, input bit gaps);
        int w;
        for (int b = 0; b < len; b++) begin
            @(negedge aclk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                @(negedge aclk);
            end
            for (int c = 0; c < CH; c++)
                s_tdata[c*32 +: 32] = {16'(fr_im[c][b]), 16'(fr_re[c][b])};
            s_index  = 32'(b);
            s_tlast  = (b == len - 1);
            s_tvalid = 1'b1;
            w = 0;
            while (!s_tready_a) begin
                @(negedge aclk);
                w++;
                if (w > 400) begin
                    $display("FAIL input_stall: tready low %0d cycles, required 1 within 400", w);
                    nfail++;
                    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
                    $fatal(1, "input never accepted");
                end
            end
            if (b == len - 1) begin
                last_e = cyc + 1;
                if (len != LEN) exp_err_cyc = cyc + 2;
                model_frame(len);
            end
        end
        @(negedge aclk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (exp_a.size() != 0 || exp_b.size() != 0) begin
            @(negedge aclk);
            w++;
            if (w > 600) begin
                ntests++;
                nfail++;
                $display("FAIL report_timeout: %0d beats outstanding, required 0", exp_a.size());
                exp_a.delete();
                exp_b.delete();
            end
        end
        repeat (2) @(negedge aclk);
    endtask

    task automatic chk_got(input string nm, input bit sel_b, input int idx,
                           input int user, input logic [31:0] pidx, input logic [31:0] pmag);
        beat_t g;
        if ((sel_b ? got_b.size() : got_a.size()) <= idx) begin
            ntests++;
            nfail++;
            $display("FAIL %s: beat %0d missing, required present", nm, idx);
        end else begin
            g = sel_b ? got_b[idx] : got_a[idx];
            chk({nm, "_user"}, 64'(g.user), 64'(user));
            chk({nm, "_data"}, g.data, {pidx, pmag});
            chk({nm, "_last"}, 64'(g.last), 64'(user == CH - 1));
        end
    endtask

    // Reset control, output-ready generation and the per-cycle comparison against the model.
    initial begin
        aresetn  = 1'b0;
        m_tready = 1'b0;
        repeat (2) @(negedge aclk);
        chk("rst_s_tready", 64'(s_tready_a), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid_a), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast_a), 64'd0);
        chk("rst_m_tdata", m_tdata_a, 64'd0);
        chk("rst_m_tuser", 64'(m_tuser_a), 64'd0);
        chk("rst_frame_err", 64'(ferr_a), 64'd0);
        aresetn  = 1'b1;
        rst_done = 1'b1;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                aresetn = 1'b1;
                chk("tvalid_after_reset_a", 64'(m_tvalid_a), 64'd0);
                chk("tvalid_after_reset_b", 64'(m_tvalid_b), 64'd0);
                chk("tready_after_reset", 64'(s_tready_a), 64'd0);
                prev_valid = 1'b0;
                m_tready   = 1'b0;
            end else begin
                chk("m_tvalid_a", 64'(m_tvalid_a), 64'(exp_a.size() != 0 && cyc >= last_e + 3));
                chk("m_tvalid_b", 64'(m_tvalid_b), 64'(exp_b.size() != 0 && cyc >= last_e + 3));
                chk("frame_err_a", 64'(ferr_a), 64'(cyc == exp_err_cyc));
                chk("frame_err_b", 64'(ferr_b), 64'(cyc == exp_err_cyc));
                if (ferr_a) err_pulses++;
                if (exp_a.size() != 0) begin
                    chk("s_tready_busy_a", 64'(s_tready_a), 64'd0);
                    chk("s_tready_busy_b", 64'(s_tready_b), 64'd0);
                end
                if (m_tvalid_a && exp_a.size() != 0)
                    chk("beat_a", {m_tlast_a, m_tuser_a, m_tdata_a}, 64'(exp_a[0]));
                if (m_tvalid_b && exp_b.size() != 0)
                    chk("beat_b", {m_tlast_b, m_tuser_b, m_tdata_b}, 64'(exp_b[0]));
                if (m_tvalid_a && !prev_valid && bp_req) begin
                    bp_left = 10;
                    bp_req  = 1'b0;
                end
                if (bp_left > 0) begin
                    m_tready = 1'b0;
                    bp_left--;
                end else begin
                    m_tready = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (rst_pending) begin
                    aresetn     = 1'b0;
                    m_tready    = 1'b0;
                    rst_pending = 1'b0;
                    exp_a.delete();
                    exp_b.delete();
                end else if (m_tvalid_a && m_tready) begin
                    got_a.push_back({m_tlast_a, m_tuser_a, m_tdata_a});
                    got_b.push_back({m_tlast_b, m_tuser_b, m_tdata_b});
                    if (rst_req && m_tuser_a == 8'd0) begin
                        rst_pending = 1'b1;
                        rst_req     = 1'b0;
                    end
                    if (exp_a.size() != 0) void'(exp_a.pop_front());
                    if (exp_b.size() != 0) void'(exp_b.pop_front());
                end
                prev_valid = m_tvalid_a;
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int n0;
        int e0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        s_index  = '0;
        wait (rst_done);

        // Basic two-channel frame
        clear_frame();
        fr_re[0][5] = 1000;
        fr_re[1][9] = -300;
        fr_im[1][9] = 400;
        n0 = got_a.size();
        send_frame(LEN, 1'b0);
        wait_idle();
        chk_got("basic_ch0", 1'b0, n0, 0, 32'd5, 32'd1000000);
        chk_got("basic_ch1", 1'b0, n0 + 1, 1, 32'd9, 32'd250000);
        chk("basic_no_err", 64'(err_pulses), 64'd0);

        // DC rejection and ties
        clear_frame();
        fr_re[0][0] = 2000;
        fr_re[0][3] = 500;
        fr_re[0][7] = 500;
        n0 = got_a.size();
        send_frame(LEN, 1'b0);
        wait_idle();
        chk_got("dc_skip1", 1'b0, n0, 0, 32'd3, 32'd250000);
        chk_got("dc_skip0", 1'b1, n0, 0, 32'd0, 32'd4000000);

        // Extremes
        clear_frame();
        fr_re[0][2] = -32768;
        fr_im[0][2] = -32768;
        n0 = got_a.size();
        send_frame(LEN, 1'b0);
        wait_idle();
        chk_got("extreme", 1'b0, n0, 0, 32'd2, 32'h80000000);
        clear_frame();
        n0 = got_a.size();
        send_frame(LEN, 1'b0);
        wait_idle();
        chk_got("zero_ch0", 1'b0, n0, 0, 32'd0, 32'd0);
        chk_got("zero_ch1", 1'b0, n0 + 1, 1, 32'd0, 32'd0);

        // Output backpressure, then a weak frame to expose carry-over
        rand_frame();
        bp_req = 1'b1;
        send_frame(LEN, 1'b0);
        wait_idle();
        clear_frame();
        fr_re[0][4] = 3;
        n0 = got_a.size();
        send_frame(LEN, 1'b0);
        wait_idle();
        chk_got("after_bp_ch0", 1'b0, n0, 0, 32'd4, 32'd9);
        chk_got("after_bp_ch1", 1'b0, n0 + 1, 1, 32'd0, 32'd0);

        // Length errors
        e0 = err_pulses;
        rand_frame();
        n0 = got_a.size();
        send_frame(10, 1'b0);
        wait_idle();
        chk("short_err_pulse", 64'(err_pulses), 64'(e0 + 1));
        chk("short_reported", 64'(got_a.size()), 64'(n0 + 2));
        rand_frame();
        send_frame(LEN, 1'b1);
        wait_idle();
        chk("good_after_short", 64'(err_pulses), 64'(e0 + 1));
        rand_frame();
        send_frame(20, 1'b1);
        wait_idle();
        chk("long_err_pulse", 64'(err_pulses), 64'(e0 + 2));

        // Reset in the middle of a report
        rand_frame();
        rst_req = 1'b1;
        n0 = got_a.size();
        send_frame(LEN, 1'b0);
        wait_idle();
        repeat (5) @(negedge aclk);
        chk("abort_one_beat", 64'(got_a.size()), 64'(n0 + 1));
        clear_frame();
        fr_re[1][6] = 7;
        n0 = got_a.size();
        send_frame(LEN, 1'b0);
        wait_idle();
        chk_got("post_reset_ch0", 1'b0, n0, 0, 32'd0, 32'd0);
        chk_got("post_reset_ch1", 1'b0, n0 + 1, 1, 32'd6, 32'd49);

        // Random frames with input gaps and random output ready
        rdy_random = 1'b1;
        for (int f = 0; f < 25; f++) begin
            rand_frame();
            case ($urandom_range(0, 4))
                0:       send_frame(12, 1'b1);
                1:       send_frame(19, 1'b1);
                default: send_frame(LEN, 1'b1);
            endcase
            wait_idle();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    // Global time limit
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        nfail++;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- Consumes the spectrum stream produced by the FFT front-end: per-channel complex bins plus bin index, with tlast marking the end of a frame.
- Computes |X|^2 for each channel and each bin, and tracks the strongest bin per channel.
- After each frame, emits one result beat per channel on an AXI-Stream master towards the packetizer.
- Acts as the downstream receiver for the FFT block's m_axis/m_index interface and drives that block's tready.

Parameters:
- FFT_LEN, 8192: expected number of bins per frame.
- FFT_CHANNELS, 2: number of channels packed in each input beat.
- FFT_AXI_DATA_WIDTH, 32: bits per channel per beat. Layout is {im[31:16], re[15:0]}, both signed two's complement.
- FFT_INDEX_LEN, 32: width of the bin index.
- SKIP_BINS, 1: bins with index < SKIP_BINS are excluded from the peak search (DC rejection). A value of 0 disables exclusion.

Ports:
- aclk, in, 1: clock.
- aresetn, in, 1: synchronous active-low reset.
- s_axis_tdata, in, FFT_CHANNELS*FFT_AXI_DATA_WIDTH: FFT bins; channel c occupies bits [32c+31:32c].
- s_axis_tvalid, in, 1: input beat valid.
- s_axis_tlast, in, 1: last bin of the frame.
- s_axis_tready, out, 1: input ready.
- s_index, in, FFT_INDEX_LEN: bin index; qualified by s_axis_tvalid & s_axis_tready.
- m_axis_tdata, out, 64: result record; [63:32] = peak index (zero-extended or truncated to 32 bits), [31:0] = peak |X|^2.
- m_axis_tuser, out, 8: channel number of the current result beat.
- m_axis_tvalid, out, 1: result beat valid.
- m_axis_tlast, out, 1: asserted on the beat for channel FFT_CHANNELS-1.
- m_axis_tready, in, 1: downstream ready.
- frame_err, out, 1: one-cycle pulse when a frame's beat count differs from FFT_LEN.

Behaviour:
- Reset is aresetn, synchronous, active-low; the block is clocked on aclk. All registers clear on reset.
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0, frame_err=0, state=CLEAR.
- Reset asserted mid-frame or mid-report aborts all activity. No partial result is ever emitted.
- States:
  - CLEAR (one cycle): zero the per-channel peak_mag, peak_idx and the beat counter; go to ACCUM.
  - ACCUM: s_axis_tready=1. A beat is accepted when tvalid&tready. When the accepted beat has tlast=1, go to DRAIN.
  - DRAIN (2 cycles): s_axis_tready=0 while the pipeline empties; then go to REPORT.
  - REPORT: s_axis_tready=0. The block presents FFT_CHANNELS beats, channel 0 first. A beat advances on m_axis_tvalid&m_axis_tready. After the beat with tlast is accepted, go to CLEAR.
- Pipeline, counted from the acceptance edge E:
  - Edge E: capture re/im, index, last and valid.
  - Edge E+1: register mag = re*re + im*im, per channel. This is an unsigned 32-bit value; its maximum is 2^31 (re=im=-32768), so no saturation is needed.
  - Edge E+2: peak update.
- Peak update rule, per channel: if valid, index >= SKIP_BINS and mag > peak_mag (strictly greater), then peak_mag <= mag and peak_idx <= index. On ties the earliest bin wins.
- If no bin qualifies, or all magnitudes are 0, the report carries mag=0 and index=0.
- m_axis_tvalid first rises on edge E+3, where E is the acceptance edge of the tlast beat. The beat is held stable until accepted (standard AXIS rules; data must not change while tvalid=1 and tready=0).
- Input backpressure: the input never stalls within ACCUM. The upstream sees tready=0 only during CLEAR, DRAIN and REPORT. The FFT core buffers its own output during that time.
- Beat counter:
  - Increments on each accepted beat, and saturates at 2^32-1.
  - On the tlast beat, if (count+1) != FFT_LEN, frame_err pulses high for exactly one cycle at edge E+1.
  - The frame is still reported normally.
- tvalid=0 gaps inside a frame are allowed and have no effect.

Test Plan:
- FFT_LEN=16, SKIP_BINS=1, continuous input.
  - Stimulus: ch0 bin 5 = {im=0, re=1000}, ch1 bin 9 = {im=400, re=-300}, all other bins 0.
  - Required response: two beats. Beat 1: tuser=0, tdata={32'd5, 32'd1000000}. Beat 2: tuser=1, tdata={32'd9, 32'd250000}, tlast=1. tvalid rises at E+3. frame_err stays 0.
- DC reject and ties.
  - Stimulus: ch0 bin 0 = re 2000; bins 3 and 7 both re 500.
  - Required response: ch0 reports index 3, mag 250000.
  - Repeat with SKIP_BINS=0: ch0 reports index 0, mag 4000000.
- Extremes.
  - Stimulus: ch0 bin 2 = {im=-32768, re=-32768}.
  - Required response: mag 32'h80000000, index 2.
  - Stimulus: all-zero frame.
  - Required response: both channels {0,0}.
- Output backpressure.
  - Stimulus: hold m_axis_tready=0 for 10 cycles during REPORT, then release.
  - Required response: beat 0 is held stable throughout; s_axis_tready stays 0; the next frame's result is correct (peaks cleared, no carry-over from the previous frame).
- Length error.
  - Stimulus: FFT_LEN=16, tlast on the 10th beat.
  - Required response: frame_err is a single-cycle pulse at E+1; a report is still emitted.
  - Stimulus: a following 16-beat frame.
  - Required response: frame_err=0.
- Reset mid-REPORT.
  - Stimulus: assert aresetn=0 for one cycle after beat 0 is accepted.
  - Required response: m_axis_tvalid=0 on the next cycle, no further beats are emitted, and a subsequent frame reports correctly.
